serial_subtractor_8bit: RTL and testbench
=========================================

# serial_subtractor_8bit

Bit-serial 8-bit subtractor: latches two unsigned/two's-complement operands on a start pulse and computes A − B one bit per clock, LSB first, through a single registered borrow flip-flop. It is the inverse-operation counterpart of the 8-bit adder datapath: a full-subtractor cell plus a borrow chain, folded in time. It sits beside the 8-bit adder and shares the same handshake style for use by a controlling sequencer.

## Interface
- WIDTH, 8, operand/result width; only 8 is supported (counter sized for 8 bits).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- SS_start  input  1  request pulse; sampled only in IDLE.
- SS_a  input  8  minuend; sampled on the accepting edge only.
- SS_b  input  8  subtrahend; sampled on the accepting edge only.
- SS_busy  output  1  high while a subtraction is in progress (SHIFT or DONE state).
- SS_done  output  1  one-cycle completion strobe.
- SS_diff  output  8  result (A − B) mod 256; holds until the next completion.
- SS_borrow  output  1  final borrow; 1 iff A < B unsigned.
- SS_ovf  output  1  signed overflow flag (see Configuration).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: if SS_start=1 on an edge, latch SS_a and SS_b into shift registers, clear the borrow flop and set bit counter to 0, then go to SHIFT. SS_start=0 keeps IDLE.
- SHIFT: each edge processes bit i = counter:
  - d = a_i ^ b_i ^ bin;
  - bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin).
  - d shifts into the result register from the MSB side, so the LSB ends at bit 0 after 8 shifts. bout goes to the borrow flop, and the counter increments.
- On the edge processing bit 7: update SS_diff, SS_borrow, SS_ovf, set SS_done=1, and go to DONE.
- DONE: one cycle only. The next edge clears SS_done and returns to IDLE unconditionally.
- SS_start in SHIFT or DONE is ignored, with no queuing. A start request needs a fresh pulse while in IDLE.
- SS_diff, SS_borrow and SS_ovf change only on the completion edge. The intermediate shift register is internal.
- Arithmetic: SS_diff = (A − B) mod 2^8. SS_borrow = borrow out of bit 7.

## Timing
- Reset (async assert, sync release) forces:
  - state IDLE, counter 0, shift registers 0;
  - SS_busy=0, SS_done=0, SS_diff=0x00, SS_borrow=0, SS_ovf=0.
- Start accepted at edge k:
  - SS_busy rises after edge k.
  - Bits 0..7 are processed at edges k+1..k+8.
  - SS_done=1 and the results are valid in the cycle after edge k+8.
  - SS_busy falls after edge k+9.
- Latency is 8 cycles from the accepting edge to results. Throughput is one operation per 10 cycles: the earliest next accept is edge k+10.
- Reset mid-operation aborts the operation. No done strobe is produced, and the outputs return to reset values immediately.
- SS_a and SS_b may change freely after the accepting edge.

## Configuration
- Macro SERIAL_SUB_OVERFLOW_EN.
- Defined: on the completion edge, SS_ovf = (A[7] != B[7]) & (SS_diff[7] != A[7]), using the latched operands. It holds with SS_diff.
- Undefined: no overflow logic is synthesized. SS_ovf stays at constant 0, and the port still exists.

## Test plan
- Reset, then start with A=0x05, B=0x03 → SS_done after 8 cycles; SS_diff=0x02, SS_borrow=0, SS_ovf=0; SS_busy high exactly 9 cycles.
- A=0x03, B=0x05 → SS_diff=0xFE, SS_borrow=1, SS_ovf=0.
- A=0x80, B=0x01 → SS_diff=0x7F, SS_borrow=0; SS_ovf=1 with the macro defined, 0 without.
- A=0x00, B=0x00 and A=0xFF, B=0xFF → SS_diff=0x00, SS_borrow=0; and A=0x00, B=0xFF → SS_diff=0x01, SS_borrow=1.
- Start A=0x10, B=0x01, then pulse SS_start with A=0x20, B=0x02 at cycle 4 → second request ignored; result 0x0F; a later start in IDLE returns 0x1E.
- Start A=0x55, B=0x11, drop rst_n at cycle 5 → outputs immediately at reset values, no SS_done; after release, a start with A=0x55, B=0x11 yields 0x44.

Source files
------------

// File: rtl/serial_subtractor_8bit_if.sv
// Start/operand/result bundle shared by the serial subtractor and its controlling sequencer.
interface serial_subtractor_8bit_if #(
  parameter int WIDTH = 8
);
  logic             SS_start;
  logic [WIDTH-1:0] SS_a;
  logic [WIDTH-1:0] SS_b;
  logic             SS_busy;
  logic             SS_done;
  logic [WIDTH-1:0] SS_diff;
  logic             SS_borrow;
  logic             SS_ovf;

  modport master (
    output SS_start, SS_a, SS_b,
    input  SS_busy, SS_done, SS_diff, SS_borrow, SS_ovf
  );

  modport slave (
    input  SS_start, SS_a, SS_b,
    output SS_busy, SS_done, SS_diff, SS_borrow, SS_ovf
  );
endinterface

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial A - B, LSB first, one full-subtractor cell with a registered borrow.
// Define SERIAL_SUB_OVERFLOW_EN to build the signed overflow flag; otherwise SS_ovf is tied to 0.
module serial_subtractor_8bit #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_subtractor_8bit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic [WIDTH-1:0] diff_reg, diff_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             bin_reg, bin_next;
  logic             borrow_reg, borrow_next;

  logic a_i, b_i, d_bit, bout;
  logic last_bit;

  // Operands shift right, so the bit under process is always at position 0.
  assign a_i      = a_reg[0];
  assign b_i      = b_reg[0];
  assign d_bit    = a_i ^ b_i ^ bin_reg;
  assign bout     = (~a_i & b_i) | (~(a_i ^ b_i) & bin_reg);
  assign last_bit = (state_reg == SHIFT) && (cnt_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      diff_reg   <= '0;
      cnt_reg    <= '0;
      bin_reg    <= 1'b0;
      borrow_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      res_reg    <= res_next;
      diff_reg   <= diff_next;
      cnt_reg    <= cnt_next;
      bin_reg    <= bin_next;
      borrow_reg <= borrow_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    res_next    = res_reg;
    diff_next   = diff_reg;
    cnt_next    = cnt_reg;
    bin_next    = bin_reg;
    borrow_next = borrow_reg;
    case (state_reg)
      IDLE: begin
        if (bus.SS_start) begin
          a_next     = bus.SS_a;
          b_next     = bus.SS_b;
          res_next   = '0;
          bin_next   = 1'b0;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        a_next   = a_reg >> 1;
        b_next   = b_reg >> 1;
        res_next = {d_bit, res_reg[WIDTH-1:1]};
        bin_next = bout;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST) begin
          diff_next   = {d_bit, res_reg[WIDTH-1:1]};
          borrow_next = bout;
          state_next  = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.SS_busy   = (state_reg != IDLE);
  assign bus.SS_done   = (state_reg == DONE);
  assign bus.SS_diff   = diff_reg;
  assign bus.SS_borrow = borrow_reg;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic ovf_reg, ovf_next;

  // On the last bit a_i/b_i are the operand sign bits and d_bit is the result sign.
  always_comb begin
    ovf_next = ovf_reg;
    if (last_bit)
      ovf_next = (a_i != b_i) && (d_bit != a_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_reg <= 1'b0;
    else        ovf_reg <= ovf_next;
  end

  assign bus.SS_ovf = ovf_reg;
`else
  logic unused_last;
  assign unused_last = last_bit;
  assign bus.SS_ovf  = 1'b0;
`endif
endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Directed vector bench for the bit-serial subtractor: table of operations plus hand-written corner sequences.
module tb_serial_subtractor_8bit;
  logic clk;
  logic rst_n;

  serial_subtractor_8bit_if #(.WIDTH(8)) bus ();

  serial_subtractor_8bit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef SERIAL_SUB_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;   // flag value when the overflow logic is built
  } vec_t;

  vec_t vecs [11];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] prev_diff = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.SS_start = 1'b1;
    bus.SS_a     = a;
    bus.SS_b     = b;
    @(posedge clk);
    #1;
    bus.SS_start = 1'b0;
    bus.SS_a     = 8'($urandom);
    bus.SS_b     = 8'($urandom);
  endtask

  // Counts edges after the accepting edge until SS_done is seen.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.SS_done !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic do_op(input string name, input vec_t v);
    int cyc;
    start_op(v.a, v.b);
    chk({name, " busy_rise"}, 32'(bus.SS_busy), 32'd1);
    chk({name, " diff_hold"}, 32'(bus.SS_diff), 32'(prev_diff));
    wait_done(cyc);
    chk({name, " latency"}, cyc, 8);
    chk({name, " diff"}, 32'(bus.SS_diff), 32'(v.diff));
    chk({name, " borrow"}, 32'(bus.SS_borrow), 32'(v.borrow));
    chk({name, " ovf"}, 32'(bus.SS_ovf), 32'(v.ovf & OVF_EN));
    $display("op %s: a=%02h b=%02h diff=%02h borrow=%0b ovf=%0b cycles=%0d",
             name, v.a, v.b, bus.SS_diff, bus.SS_borrow, bus.SS_ovf, cyc);
    @(posedge clk);
    #1;
    chk({name, " done_fall"}, 32'(bus.SS_done), 32'd0);
    chk({name, " busy_fall"}, 32'(bus.SS_busy), 32'd0);
    prev_diff = v.diff;
  endtask

  initial begin
    int   cyc;
    logic saw_done;
    vec_t v;

    vecs[0]  = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2]  = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[3]  = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[6]  = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[7]  = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1};
    vecs[8]  = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};
    vecs[9]  = '{8'h3C, 8'h0F, 8'h2D, 1'b0, 1'b0};
    vecs[10] = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1};

    rst_n        = 1'b0;
    bus.SS_start = 1'b0;
    bus.SS_a     = 8'h00;
    bus.SS_b     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(bus.SS_busy), 32'd0);
    chk("reset done", 32'(bus.SS_done), 32'd0);
    chk("reset diff", 32'(bus.SS_diff), 32'd0);
    chk("reset borrow", 32'(bus.SS_borrow), 32'd0);
    chk("reset ovf", 32'(bus.SS_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle no start", 32'(bus.SS_busy), 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Start during SHIFT must be ignored, not queued.
    start_op(8'h10, 8'h01);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.SS_start = 1'b1;
    bus.SS_a     = 8'h20;
    bus.SS_b     = 8'h02;
    @(negedge clk);
    bus.SS_start = 1'b0;
    #1;
    wait_done(cyc);
    chk("ignore done", 32'(bus.SS_done), 32'd1);
    chk("ignore diff", 32'(bus.SS_diff), 32'h0F);
    $display("op ignore: diff=%02h borrow=%0b", bus.SS_diff, bus.SS_borrow);
    prev_diff = 8'h0F;
    @(posedge clk);
    #1;
    chk("ignore idle", 32'(bus.SS_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("no queued op", 32'(bus.SS_busy), 32'd0);
    v = '{8'h20, 8'h02, 8'h1E, 1'b0, 1'b0};
    do_op("after_ignore", v);

    // Reset mid-operation aborts with no done strobe.
    start_op(8'h55, 8'h11);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(bus.SS_busy), 32'd0);
    chk("abort done", 32'(bus.SS_done), 32'd0);
    chk("abort diff", 32'(bus.SS_diff), 32'd0);
    chk("abort borrow", 32'(bus.SS_borrow), 32'd0);
    chk("abort ovf", 32'(bus.SS_ovf), 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.SS_done === 1'b1) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.SS_done === 1'b1) saw_done = 1'b1;
    end
    chk("abort no done", 32'(saw_done), 32'd0);
    $display("op abort: diff=%02h busy=%0b", bus.SS_diff, bus.SS_busy);
    prev_diff = 8'h00;
    v = '{8'h55, 8'h11, 8'h44, 1'b0, 1'b0};
    do_op("after_reset", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
